seq_right_shift16: RTL and testbench
====================================

Name: seq_right_shift16

Overview:
Multi-cycle right shifter: the opposite direction of the team's combinational 16-bit left shifter.
- Accepts operand a and shift amount b over a valid/ready handshake.
- Shifts by up to STEP positions per clock, then holds the result until the consumer accepts it.
- Serves area-constrained datapath slots in the accelerator (normalisation, scaling) where a full barrel shifter is too costly.

Parameters:
WIDTH, 16, data width of a and out.
STEP, 4, max bit positions shifted per clock. Legal values: 1, 2, 4, 8; power of two, 1..WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
in_valid  input  1  a/b valid
in_ready  output  1  block can accept new operands
a  input  WIDTH  operand
b  input  16  shift amount, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; in_ready=1, out_valid=0, busy=0, out=0, internal remaining count=0.
- Reset wins over every other event. Reset mid-operation discards the operation; no out_valid pulse is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch data_r=a;
    - remaining=min(b,WIDTH), with any b>=WIDTH clamped to WIDTH;
    - next state = SHIFT if remaining>0, else DONE with out=a.
  - SHIFT: in_ready=0. Each cycle:
    - k=min(STEP,remaining);
    - data_r>>=k, logical, zero fill;
    - remaining-=k;
    - when remaining becomes 0, next state=DONE.
  - DONE: out_valid=1, out=data_r, stable until out_ready=1. On out_valid&&out_ready, next state=IDLE and out_valid drops the following cycle.
- Latency from accept edge to out_valid high:
  - 1 + ceil(min(b,WIDTH)/STEP) cycles;
  - b=0 gives 1 cycle.
- Throughput: no overlap. The next accept occurs at the earliest 1 cycle after the result handshake, because in_ready is asserted only in IDLE.
- in_valid/a/b are ignored outside IDLE.
- out holds its last value after the result handshake until the next DONE. It is not cleared except by reset.
- b>=WIDTH, e.g. 16 or 0xFFFF: result 0 (logical), after ceil(WIDTH/STEP) shift cycles. No wrap of the shift amount.
- out_ready held high in DONE: single-cycle DONE, back-to-back with the next IDLE.
- out_ready asserted outside DONE: no effect.

Optional Feature:
Macro SEQ_RIGHT_SHIFT_ARITH_EN.
- Defined:
  - extra input port arith (1 bit), sampled at accept;
  - when arith=1 the shift is arithmetic: vacated bits filled with a[WIDTH-1];
  - b>=WIDTH yields all-ones if a is negative, else 0;
  - the fill bit is latched at accept.
- Undefined: port absent; logical shift only; behaviour exactly as above.

Decomposition:
- Shared package shift_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - localparam for the remaining-counter width, $clog2(WIDTH+1);
  - STEP legality check constant.
- One natural sub-module: shift_step. Combinational right shift of WIDTH bits by k in 0..STEP, with fill-bit input. Instantiated once in the datapath.

Test Plan:
- Reset then a=16'h8001, b=1, STEP=4, out_ready=1 -> out_valid 2 cycles after accept, out=16'h4000, then in_ready=1 next cycle.
- a=16'hF0F0, b=0 -> out_valid 1 cycle after accept, out=16'hF0F0.
- a=16'hFFFF, b=15 -> 4 SHIFT cycles (4,4,4,3), out=16'h0001; also b=16 and b=16'hFFFF -> out=0 after 4 shift cycles.
- out_ready held 0 for 5 cycles in DONE with a=16'h1234, b=4 -> out=16'h0123 and out_valid stay stable; new in_valid with other data ignored; accepted only after the result handshake.
- rst_n=0 pulsed during SHIFT of a=16'hFFFF, b=12 -> next cycle IDLE, in_ready=1, out_valid=0, out=0; no result emitted.
- With SEQ_RIGHT_SHIFT_ARITH_EN: a=16'h8000, b=3, arith=1 -> out=16'hF000; arith=0 -> out=16'h1000; a=16'h8000, b=20, arith=1 -> out=16'hFFFF.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state enum, counter width and STEP legality for the sequential right shifter
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 16;
  localparam int STEP_DEFAULT  = 4;

  // Remaining-count width must hold WIDTH itself, not just WIDTH-1.
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic bit step_legal(input int step, input int width);
    return (step >= 1) && (step <= width) && ((step & (step - 1)) == 0);
  endfunction

  localparam bit STEP_DEFAULT_OK = step_legal(STEP_DEFAULT, WIDTH_DEFAULT);

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational right shift of WIDTH bits by 0..STEP with a fill bit
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int STEP  = STEP_DEFAULT,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] d,
  input  logic [KW-1:0]    k,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] vacated;

  // Vacated positions are the bits a logical shift of all-ones leaves clear.
  always_comb begin
    ones    = '1;
    vacated = ~(ones >> k);
    q       = (d >> k) | (vacated & {WIDTH{fill}});
  end

endmodule

// File: rtl/seq_right_shift16.sv
// rtl/seq_right_shift16.sv - multi-cycle right shifter, optional arithmetic mode via SEQ_RIGHT_SHIFT_ARITH_EN
module seq_right_shift16
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int STEP  = STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [15:0]      b,
`ifdef SEQ_RIGHT_SHIFT_ARITH_EN
  input  logic             arith,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int KW    = $clog2(STEP + 1);

  if (!step_legal(STEP, WIDTH)) begin : g_bad_step
    $error("seq_right_shift16: STEP must be a power of two in 1..WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [KW-1:0]    k_step;
  logic [WIDTH-1:0] shifted;
  logic             fill_in;

  always_comb begin
    if (rem_q < CNT_W'(STEP)) k_step = KW'(rem_q);
    else                      k_step = KW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_shift_step (
    .d    (data_q),
    .k    (k_step),
    .fill (fill_q),
    .q    (shifted)
  );

`ifdef SEQ_RIGHT_SHIFT_ARITH_EN
  assign fill_in = arith & a[WIDTH-1];
`else
  assign fill_in = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rem_d       = rem_q;
    fill_d      = fill_q;
    out_d       = out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = a;
          fill_d     = fill_in;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          // Oversized shift amounts saturate to WIDTH rather than wrapping.
          if (b >= 16'(WIDTH)) rem_d = CNT_W'(WIDTH);
          else                 rem_d = CNT_W'(b);
          if (b == 16'd0) begin
            state_d     = DONE;
            out_d       = a;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - CNT_W'(k_step);
        if (rem_q == CNT_W'(k_step)) begin
          state_d     = DONE;
          out_d       = shifted;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      fill_q      <= 1'b0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      fill_q      <= fill_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_right_shift16.sv
// tb/tb_seq_right_shift16.sv - scoreboard bench for seq_right_shift16 (STEP=4, WIDTH=16)
module tb_seq_right_shift16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int n_checks;
  int n_pass;

  logic [15:0] exp_q[$];
  int          lat_q[$];

  seq_right_shift16 #(.WIDTH(16), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SEQ_RIGHT_SHIFT_ARITH_EN
    .arith     (arith),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model(input logic [15:0] av, input logic [15:0] bv, input logic ar);
    logic signed [16:0] ext;
    logic signed [16:0] res;
    int eff;
    eff = (bv >= 16) ? 16 : int'(bv);
`ifdef SEQ_RIGHT_SHIFT_ARITH_EN
    ext = {ar & av[15], av};
`else
    ext = {1'b0, av};
    if (ar) ext = {1'b0, av};
`endif
    res = ext >>> eff;
    return res[15:0];
  endfunction

  function automatic int model_lat(input logic [15:0] bv);
    int eff;
    eff = (bv >= 16) ? 16 : int'(bv);
    return 1 + (eff + 3) / 4;
  endfunction

  // hold = cycles out_ready stays low in DONE; hold 0 keeps out_ready high throughout.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ar, input int hold);
    int          lat;
    int          guard;
    logic [15:0] got;
    logic [15:0] exp_v;
    int          exp_lat;
    @(negedge clk);
    a         = av;
    b         = bv;
    arith     = ar;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("accept_timeout", 32'(guard), 32'd0);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(av, bv, ar));
    lat_q.push_back(model_lat(bv));
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~av;
    b        = 16'd0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = lat_q.pop_front();
    check("latency", 32'(lat), 32'(exp_lat));
    got = out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("done_hold_valid", 32'(out_valid), 32'd1);
      check("done_hold_out", 32'(out), 32'(got));
      check("done_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    check("result", 32'(got), 32'(exp_v));
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("out_held", 32'(out), 32'(exp_v));
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    rst_n = 1'b1;

    run_op(16'h8001, 16'd1, 1'b0, 0);
    run_op(16'hF0F0, 16'd0, 1'b0, 0);
    run_op(16'hFFFF, 16'd15, 1'b0, 0);
    run_op(16'hFFFF, 16'd16, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0);
    run_op(16'h1234, 16'd4, 1'b0, 5);

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    a        = 16'hFFFF;
    b        = 16'd12;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_shift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("mid_rst_no_result", 32'(seen), 32'd0);
    end

`ifdef SEQ_RIGHT_SHIFT_ARITH_EN
    run_op(16'h8000, 16'd3, 1'b1, 0);
    run_op(16'h8000, 16'd3, 1'b0, 0);
    run_op(16'h8000, 16'd20, 1'b1, 0);
    run_op(16'h7FFF, 16'd20, 1'b1, 1);
`endif

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
